// File: rtl/hs_rx_deserializer.sv
// HS receive front-end: hunts for the sync word, deserializes LSB-first into bytes and
// delays them so trailer bits can be dropped before they reach the byte side.
module hs_rx_deserializer #(
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter int         DELAY_BYTES  = 24,
  parameter int         HUNT_TIMEOUT = 1024
) (
  input  logic       clk_hs_rx,
  input  logic       RST,
  input  logic       rx_enable,
  input  logic       HS_RX_DATA,
  input  logic       trailer_done,
  input  logic       break_trailer_c,
  output logic       comparator_enable,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_sot_done,
  output logic       rx_eot,
  output logic       sync_error,
  output logic [3:0] false_trailer_cnt
);

  localparam int PTR_W  = (DELAY_BYTES > 1) ? $clog2(DELAY_BYTES) : 1;
  localparam int OCC_W  = $clog2(DELAY_BYTES + 1);
  localparam int HCNT_W = $clog2(HUNT_TIMEOUT + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DELAY_BYTES - 1);
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DELAY_BYTES);
  localparam logic [HCNT_W-1:0] HUNT_LAST = HCNT_W'(HUNT_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_DATA, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         sr_q, sr_d, sr_shift;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [HCNT_W-1:0]  hunt_cnt_q, hunt_cnt_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               cmp_en_q, cmp_en_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               valid_q, valid_d;
  logic               sot_q, sot_d;
  logic               eot_q, eot_d;
  logic               serr_q, serr_d;
  logic [3:0]         ftc_q, ftc_d;
  logic               push;
  logic [7:0]         mem_q [DELAY_BYTES];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign sr_shift = {HS_RX_DATA, sr_q[7:1]};

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    hunt_cnt_d = hunt_cnt_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rx_byte_d  = rx_byte_q;
    valid_d    = 1'b0;
    sot_d      = 1'b0;
    eot_d      = 1'b0;
    serr_d     = serr_q;
    ftc_d      = ftc_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_enable) begin
          state_d    = S_HUNT;
          sr_d       = '0;
          hunt_cnt_d = '0;
          ftc_d      = '0;
          serr_d     = 1'b0;
        end
      end
      S_HUNT: begin
        if (!rx_enable) begin
          state_d = S_IDLE;
        end else begin
          sr_d = sr_shift;
          if (sr_shift == SYNC_WORD) begin
            state_d  = S_DATA;
            sot_d    = 1'b1;
            bitcnt_d = '0;
          end else if (hunt_cnt_q == HUNT_LAST) begin
            serr_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            hunt_cnt_d = hunt_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (!rx_enable) begin
          state_d = S_IDLE;
        end else begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 3'd1;
          if (break_trailer_c && (ftc_q != 4'hF)) ftc_d = ftc_q + 4'd1;
          // A trailer hit on a byte boundary suppresses that push and its pop.
          if (trailer_done) begin
            eot_d   = 1'b1;
            state_d = S_DONE;
          end else if (bitcnt_q == 3'd7) begin
            push     = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (occ_q == OCC_FULL) begin
              valid_d   = 1'b1;
              rx_byte_d = mem_q[rd_ptr_q];
              rd_ptr_d  = ptr_inc(rd_ptr_q);
            end else begin
              occ_d = occ_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (!rx_enable) begin
          state_d = S_IDLE;
          serr_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving a burst drops the partial byte and everything still buffered.
    if ((state_d != state_q) && ((state_d == S_IDLE) || (state_d == S_DONE))) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      bitcnt_d = '0;
      sr_d     = '0;
    end

    cmp_en_d = (state_d == S_DATA);
  end

  always_ff @(posedge clk_hs_rx) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      hunt_cnt_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmp_en_q   <= 1'b0;
      rx_byte_q  <= '0;
      valid_q    <= 1'b0;
      sot_q      <= 1'b0;
      eot_q      <= 1'b0;
      serr_q     <= 1'b0;
      ftc_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      hunt_cnt_q <= hunt_cnt_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmp_en_q   <= cmp_en_d;
      rx_byte_q  <= rx_byte_d;
      valid_q    <= valid_d;
      sot_q      <= sot_d;
      eot_q      <= eot_d;
      serr_q     <= serr_d;
      ftc_q      <= ftc_d;
    end
  end

  always_ff @(posedge clk_hs_rx) begin
    if (push) mem_q[wr_ptr_q] <= sr_shift;
  end

  assign comparator_enable = cmp_en_q;
  assign rx_byte           = rx_byte_q;
  assign rx_byte_valid     = valid_q;
  assign rx_sot_done       = sot_q;
  assign rx_eot            = eot_q;
  assign sync_error        = serr_q;
  assign false_trailer_cnt = ftc_q;

endmodule

// File: tb/tb_hs_rx_deserializer.sv
// Directed table-driven bench for hs_rx_deserializer (DELAY_BYTES=2, HUNT_TIMEOUT=64).
module tb_hs_rx_deserializer;

  localparam logic [7:0] SYNC = 8'hB8;

  logic       clk = 1'b0;
  logic       rst_n, rx_enable, din, td, bt;
  logic       cmp_en, rx_byte_valid, rx_sot_done, rx_eot, sync_error;
  logic [7:0] rx_byte;
  logic [3:0] ftc;

  always #5 clk = ~clk;

  hs_rx_deserializer #(.SYNC_WORD(8'hB8), .DELAY_BYTES(2), .HUNT_TIMEOUT(64)) dut (
    .clk_hs_rx(clk), .RST(rst_n), .rx_enable(rx_enable), .HS_RX_DATA(din),
    .trailer_done(td), .break_trailer_c(bt), .comparator_enable(cmp_en),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_sot_done(rx_sot_done),
    .rx_eot(rx_eot), .sync_error(sync_error), .false_trailer_cnt(ftc)
  );

  typedef struct {
    logic       rst_n, en, din, td, bt;
    logic       e_sot, e_val, e_eot, e_cmp, e_serr;
    logic [7:0] e_byte;
    logic [3:0] e_ftc;
  } vec_t;

  vec_t       vq[$];
  logic       cur_cmp, cur_serr;
  logic [7:0] cur_byte;
  logic [3:0] cur_ftc;
  int         checks = 0;
  int         failures = 0;

  function void add(input logic r, input logic en, input logic d, input logic t,
                    input logic b, input logic sot, input logic val, input logic eot);
    vec_t v;
    v.rst_n = r;  v.en = en;  v.din = d;  v.td = t;  v.bt = b;
    v.e_sot = sot;  v.e_val = val;  v.e_eot = eot;
    v.e_cmp = cur_cmp;  v.e_serr = cur_serr;  v.e_byte = cur_byte;  v.e_ftc = cur_ftc;
    vq.push_back(v);
  endfunction

  function void send_sync();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) cur_cmp = 1'b1;
      add(1'b1, 1'b1, SYNC[i], 1'b0, 1'b0, (i == 7), 1'b0, 1'b0);
    end
  endfunction

  function void send_byte(input logic [7:0] b, input logic pop, input logic [7:0] popped,
                          input int bt_pos);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && pop) cur_byte = popped;
      if (i == bt_pos) cur_ftc = (cur_ftc == 4'hF) ? 4'hF : 4'(cur_ftc + 4'd1);
      add(1'b1, 1'b1, b[i], 1'b0, (i == bt_pos), 1'b0, (i == 7) && pop, 1'b0);
    end
  endfunction

  function void build();
    logic [7:0] b3;
    b3 = 8'h03;
    cur_cmp = 1'b0;  cur_serr = 1'b0;  cur_byte = 8'h00;  cur_ftc = 4'd0;
    // Power-on reset, then a burst: 16 zero bits, sync, four bytes.
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_sync();
    send_byte(8'h11, 1'b0, 8'h00, 8);
    send_byte(8'h22, 1'b0, 8'h00, 8);
    send_byte(8'h33, 1'b1, 8'h11, 8);
    send_byte(8'h44, 1'b1, 8'h22, 8);
    // Abort mid-byte: back to IDLE with no rx_eot.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_cmp = 1'b0;
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Trailer discard mid-byte, then DONE ignores sync and trailer inputs.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_sync();
    send_byte(8'hA5, 1'b0, 8'h00, 8);
    send_byte(8'h5A, 1'b0, 8'h00, 8);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_cmp = 1'b0;
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b1, SYNC[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Trailer on the completing edge of a byte that would pop.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_sync();
    send_byte(8'h01, 1'b0, 8'h00, 2);
    send_byte(8'h02, 1'b0, 8'h00, 5);
    for (int i = 0; i < 7; i++) add(1'b1, 1'b1, b3[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_cmp = 1'b0;
    add(1'b1, 1'b1, b3[7], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // New burst clears the counter; hunt ignores break pulses; 17 pulses saturate.
    cur_ftc = 4'd0;
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_sync();
    for (int i = 1; i <= 17; i++) begin
      cur_ftc = (i > 15) ? 4'd15 : 4'(i);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    // Reset in the middle of DATA.
    cur_cmp = 1'b0;  cur_ftc = 4'd0;  cur_byte = 8'h00;
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic d, input logic t,
                      input logic b);
    @(negedge clk);
    rst_n = r;  rx_enable = en;  din = d;  td = t;  bt = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;  rx_enable = 1'b0;  din = 1'b0;  td = 1'b0;  bt = 1'b0;
    build();
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst_n, vq[i].en, vq[i].din, vq[i].td, vq[i].bt);
      check("sot",   i, {7'd0, rx_sot_done},   {7'd0, vq[i].e_sot});
      check("valid", i, {7'd0, rx_byte_valid}, {7'd0, vq[i].e_val});
      check("eot",   i, {7'd0, rx_eot},        {7'd0, vq[i].e_eot});
      check("cmp",   i, {7'd0, cmp_en},        {7'd0, vq[i].e_cmp});
      check("serr",  i, {7'd0, sync_error},    {7'd0, vq[i].e_serr});
      check("byte",  i, rx_byte,               vq[i].e_byte);
      check("ftc",   i, {4'd0, ftc},           {4'd0, vq[i].e_ftc});
    end

    // Hunt timeout: 64 alternating bits, no sync -> sticky error until rx_enable drops.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("to_entry_serr", 0, {7'd0, sync_error}, 8'd0);
    for (int k = 1; k <= 64; k++) begin
      step(1'b1, 1'b1, ((k % 2) == 0), 1'b0, 1'b0);
      check("to_serr", k, {7'd0, sync_error}, {7'd0, (k == 64)});
      check("to_sot",  k, {7'd0, rx_sot_done}, 8'd0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("to_hold", k, {7'd0, sync_error}, 8'd1);
      check("to_cmp",  k, {7'd0, cmp_en}, 8'd0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_clear", 0, {7'd0, sync_error}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
